// File: rtl/module_teclado_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package pkg_teclado;

  typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;

  localparam int unsigned N_COLS = 4;
  localparam int unsigned N_ROWS = 4;

  // Active-low one-hot column drive for column idx.
  function automatic logic [N_COLS-1:0] onehot_low(input logic [1:0] idx);
    logic [N_COLS-1:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  // {valid, idx}: valid only when exactly one row is pulled low.
  function automatic logic [2:0] row_index(input logic [N_ROWS-1:0] fila);
    logic [2:0] r;
    r = 3'b000;
    case (fila)
      4'b1110: r = 3'b100;
      4'b1101: r = 3'b101;
      4'b1011: r = 3'b110;
      4'b0111: r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/module_teclado_sync2.sv
// Two-flop synchronizer for asynchronous inputs; reset value is all-ones
// so that idle pulled-up lines read as inactive.
module module_sync2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ff1_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ff1_q <= '1;
      q     <= '1;
    end else begin
      ff1_q <= d;
      q     <= ff1_q;
    end
  end

endmodule

// File: rtl/module_teclado.sv
// 4x4 keypad scanner: column scan, press/release debounce, key code output
// with a ready flag (active low) and a one-cycle acceptance pulse.
module module_teclado
  import pkg_teclado::*;
#(
  parameter int unsigned SCAN_DIV     = 27000,
  parameter int unsigned DEBOUNCE_CYC = 270000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] fila_i,
  output logic [N_COLS-1:0] col_o,
  output logic [1:0]        dato_codc_o,
  output logic [1:0]        dato_codf_o,
  output logic              dato_listo_o,
  output logic              tecla_pulso_o
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYC);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);

  state_t              state_q, state_d;
  logic [1:0]          col_q, col_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
  logic [1:0]          cand_col_q, cand_col_d;
  logic [1:0]          cand_row_q, cand_row_d;
  logic [1:0]          codc_q, codc_d;
  logic [1:0]          codf_q, codf_d;
  logic                listo_q, listo_d;
  logic                pulso_q, pulso_d;

  logic [N_ROWS-1:0]   fila_s;
  logic [2:0]          row_info;
  logic                row_hit;
  logic [1:0]          row_idx;
  logic                cand_hit;
  logic                cand_high;
  logic [1:0]          col_next;

  module_sync2 #(
    .WIDTH(N_ROWS)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (fila_i),
    .q  (fila_s)
  );

  assign row_info  = row_index(fila_s);
  assign row_hit   = row_info[2];
  assign row_idx   = row_info[1:0];
  // Only the latched row is watched once a candidate exists; other keys are ignored.
  assign cand_hit  = row_hit && (row_idx == cand_row_q);
  assign cand_high = fila_s[cand_row_q];
  assign col_next  = (col_q == 2'(N_COLS - 1)) ? 2'd0 : col_q + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= SCAN;
      col_q      <= '0;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      cand_col_q <= '0;
      cand_row_q <= '0;
      codc_q     <= '0;
      codf_q     <= '0;
      listo_q    <= 1'b1;
      pulso_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      cand_col_q <= cand_col_d;
      cand_row_q <= cand_row_d;
      codc_q     <= codc_d;
      codf_q     <= codf_d;
      listo_q    <= listo_d;
      pulso_q    <= pulso_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    cand_col_d = cand_col_q;
    cand_row_d = cand_row_q;
    codc_d     = codc_q;
    codf_d     = codf_q;
    listo_d    = listo_q;
    pulso_d    = 1'b0;
    unique case (state_q)
      SCAN: begin
        // Rows are judged only at the end of the dwell so the synchronizer has settled.
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (row_hit) begin
            cand_col_d = col_q;
            cand_row_d = row_idx;
            deb_cnt_d  = '0;
            state_d    = DEB_PRESS;
          end else begin
            col_d = col_next;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
      DEB_PRESS: begin
        if (cand_hit) begin
          if (deb_cnt_q == DEB_LAST) begin
            state_d = PRESSED;
            codc_d  = cand_col_q;
            codf_d  = cand_row_q;
            listo_d = 1'b0;
            pulso_d = 1'b1;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end else begin
          state_d    = SCAN;
          col_d      = col_next;
          scan_cnt_d = '0;
        end
      end
      PRESSED: begin
        if (cand_high) begin
          state_d   = DEB_RELEASE;
          deb_cnt_d = '0;
        end
      end
      DEB_RELEASE: begin
        if (!cand_high) begin
          state_d = PRESSED;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d    = SCAN;
          listo_d    = 1'b1;
          col_d      = col_next;
          scan_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    col_o         = onehot_low(col_q);
    dato_codc_o   = codc_q;
    dato_codf_o   = codf_q;
    dato_listo_o  = listo_q;
    tecla_pulso_o = pulso_q;
  end

endmodule

// File: tb/tb_module_teclado.sv
// Directed bench for the keypad scanner: a keypad model closes rows against the
// driven column, and a behavioural reference is compared against the outputs every cycle.
module tb_module_teclado;

  localparam int SD = 4;
  localparam int DC = 8;

  logic       clk;
  logic       rst;
  logic [3:0] fila_i;
  logic [3:0] col_o;
  logic [1:0] dato_codc_o;
  logic [1:0] dato_codf_o;
  logic       dato_listo_o;
  logic       tecla_pulso_o;

  logic [15:0] keys;     // bit r*4+c: key at row r, column c is closed
  logic        ovr_en;
  logic [3:0]  ovr_val;

  int vectors;
  int misses;
  int pcount;
  bit cmp_en;

  // Reference state: phase 0 scanning, 1 confirming press, 2 held, 3 confirming release.
  int         m_phase, m_col, m_dwell, m_run, m_crow, m_ccol, m_cc, m_cf;
  bit         m_listo, m_pulse;
  logic [3:0] m_s1, m_s2;

  module_teclado #(
    .SCAN_DIV    (SD),
    .DEBOUNCE_CYC(DC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fila_i       (fila_i),
    .col_o        (col_o),
    .dato_codc_o  (dato_codc_o),
    .dato_codf_o  (dato_codf_o),
    .dato_listo_o (dato_listo_o),
    .tecla_pulso_o(tecla_pulso_o)
  );

  function automatic logic [3:0] keypad_rows(input logic [3:0] cols, input logic [15:0] k);
    logic [3:0] rows;
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (k[r*4+c] && cols[c] === 1'b0) rows[r] = 1'b0;
    return rows;
  endfunction

  assign fila_i = ovr_en ? ovr_val : keypad_rows(col_o, keys);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] seen;
    int lows, ridx;
    if (!rst) begin
      m_phase = 0; m_col = 0; m_dwell = 0; m_run = 0; m_crow = 0; m_ccol = 0;
      m_cc = 0; m_cf = 0; m_listo = 1'b1; m_pulse = 1'b0;
      m_s1 = 4'hf; m_s2 = 4'hf;
      return;
    end
    seen = m_s2;
    m_s2 = m_s1;
    m_s1 = fila_i;
    lows = 0;
    ridx = 0;
    for (int r = 0; r < 4; r++)
      if (!seen[r]) begin
        lows++;
        ridx = r;
      end
    m_pulse = 1'b0;
    case (m_phase)
      0: begin
        m_dwell++;
        if (m_dwell == SD) begin
          m_dwell = 0;
          if (lows == 1) begin
            m_crow = ridx; m_ccol = m_col; m_run = 0; m_phase = 1;
          end else begin
            m_col = (m_col + 1) % 4;
          end
        end
      end
      1: begin
        if (lows == 1 && ridx == m_crow) begin
          m_run++;
          if (m_run == DC) begin
            m_phase = 2; m_cc = m_ccol; m_cf = m_crow; m_listo = 1'b0; m_pulse = 1'b1;
          end
        end else begin
          m_phase = 0; m_col = (m_col + 1) % 4; m_dwell = 0;
        end
      end
      2: begin
        if (seen[m_crow]) begin
          m_phase = 3; m_run = 0;
        end
      end
      default: begin
        if (!seen[m_crow]) begin
          m_phase = 2;
        end else begin
          m_run++;
          if (m_run == DC) begin
            m_phase = 0; m_listo = 1'b1; m_col = (m_col + 1) % 4; m_dwell = 0;
          end
        end
      end
    endcase
  endtask

  // One clock: compare and advance the reference at negedge, then land at posedge+2.
  task automatic tick(input int n);
    logic [3:0] one;
    logic [9:0] exp_v, act_v;
    one = 4'b0001;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cmp_en) begin
        exp_v = {~(one << m_col), 2'(m_cc), 2'(m_cf), m_listo, m_pulse};
        act_v = {col_o, dato_codc_o, dato_codf_o, dato_listo_o, tecla_pulso_o};
        check("outputs", 32'(act_v), 32'(exp_v));
      end
      model_step();
      @(posedge clk);
      #2;
      if (tecla_pulso_o === 1'b1) pcount++;
    end
  endtask

  task automatic wait_listo(input logic v, input int lim, input string name);
    int n;
    n = 0;
    while (dato_listo_o !== v && n < lim) begin
      tick(1);
      n++;
    end
    check(name, 32'(dato_listo_o), 32'(v));
  endtask

  initial begin
    vectors = 0; misses = 0; pcount = 0; cmp_en = 1'b0;
    rst = 1'b0; keys = '0; ovr_en = 1'b1; ovr_val = 4'b0000;

    // Reset with all rows forced low
    tick(1);
    cmp_en = 1'b1;
    tick(2);
    check("rst_col", 32'(col_o), 32'(4'b1110));
    check("rst_listo", 32'(dato_listo_o), 32'd1);
    check("rst_pulse", 32'(tecla_pulso_o), 32'd0);
    check("rst_codes", 32'({dato_codc_o, dato_codf_o}), 32'd0);
    rst = 1'b1; ovr_en = 1'b0;
    tick(2);
    check("rot_c0", 32'(col_o), 32'(4'b1110));
    tick(3);
    check("rot_c1", 32'(col_o), 32'(4'b1101));
    tick(4);
    check("rot_c2", 32'(col_o), 32'(4'b1011));
    tick(4);
    check("rot_c3", 32'(col_o), 32'(4'b0111));

    // Clean press: row 3, column 1
    pcount = 0;
    keys = 16'h0001 << 13;
    wait_listo(1'b0, 4*SD + 2 + DC, "press_latency");
    tick(14);
    check("press_codc", 32'(dato_codc_o), 32'd1);
    check("press_codf", 32'(dato_codf_o), 32'd3);
    check("press_pulses", 32'(pcount), 32'd1);
    keys = '0;
    tick(10);
    check("release_early", 32'(dato_listo_o), 32'd0);
    tick(1);
    check("release_on_time", 32'(dato_listo_o), 32'd1);
    check("release_codes_kept", 32'({dato_codc_o, dato_codf_o}), 32'(4'b0111));

    // Bouncy press: row 0, column 2
    pcount = 0;
    for (int i = 0; i < 20; i++) begin
      keys = (((i / 3) % 2) == 0) ? (16'h0001 << 2) : 16'h0000;
      tick(1);
    end
    check("bounce_no_pulse", 32'(pcount), 32'd0);
    keys = 16'h0001 << 2;
    wait_listo(1'b0, 40, "bounce_accept");
    check("bounce_pulses", 32'(pcount), 32'd1);
    check("bounce_codes", 32'({dato_codc_o, dato_codf_o}), 32'(4'b1000));
    keys = '0;
    wait_listo(1'b1, 20, "bounce_release");

    // Bouncy release: row 2, column 3
    keys = 16'h0001 << 11;
    wait_listo(1'b0, 40, "brel_accept");
    tick(3);
    pcount = 0;
    keys = '0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("brel_hold_hi", 32'(dato_listo_o), 32'd0);
    end
    keys = 16'h0001 << 11;
    tick(2);
    check("brel_hold_lo", 32'(dato_listo_o), 32'd0);
    keys = '0;
    tick(10);
    check("brel_early", 32'(dato_listo_o), 32'd0);
    tick(1);
    check("brel_on_time", 32'(dato_listo_o), 32'd1);
    check("brel_no_pulse", 32'(pcount), 32'd0);

    // Two keys on column 0 (rows 0 and 2): rejected
    pcount = 0;
    keys = 16'h0101;
    tick(24);
    check("multi_listo", 32'(dato_listo_o), 32'd1);
    check("multi_pulses", 32'(pcount), 32'd0);
    keys = '0;
    tick(4);

    // Reset while held: row 1, column 2
    keys = 16'h0001 << 6;
    wait_listo(1'b0, 40, "mid_accept");
    tick(3);
    rst = 1'b0;
    tick(1);
    check("mid_rst_listo", 32'(dato_listo_o), 32'd1);
    check("mid_rst_col", 32'(col_o), 32'(4'b1110));
    check("mid_rst_codes", 32'({dato_codc_o, dato_codf_o}), 32'd0);
    rst = 1'b1;
    pcount = 0;
    wait_listo(1'b0, 40, "mid_reacquire");
    check("mid_pulses", 32'(pcount), 32'd1);
    check("mid_codes", 32'({dato_codc_o, dato_codf_o}), 32'(4'b1001));
    keys = '0;
    wait_listo(1'b1, 20, "mid_release");
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
